// File: rtl/axis_uart_tx_if.sv
// AXI4-Stream byte channel feeding the UART transmitter.
// The master drives data/valid; the transmitter (slave) drives ready.
interface axis_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_tx.sv
// AXI4-Stream to UART transmitter.
// Accepts one word per frame from the stream and serialises it as
// start bit, DATA_WIDTH data bits (LSB first), optional parity bit and
// STOP_BITS stop bits, each bit lasting CLKS_PER_BIT clock cycles.
module axis_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,   // 0 = none, 1 = odd, 2 = even
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          reset,
    axis_uart_tx_if.slave s,
    output logic          txd,
    output logic          busy,
    output logic          done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    // done must be high during the last cycle of the final stop bit, so the
    // registered pulse is launched one cycle earlier.
    localparam logic [BAUD_W-1:0] BAUD_PRE   = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic              ODD_PARITY = (PARITY == 1);
    localparam logic              HAS_PARITY = (PARITY != 0);

    // Reject parameter values the frame format cannot express.
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("axis_uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("axis_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("axis_uart_tx: DATA_WIDTH must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("axis_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q;
    logic [BAUD_W-1:0]       baud_q;
    logic [BAUD_W-1:0]       baud_d;
    logic                    bit_end;
    logic [BIT_W-1:0]        bit_q;
    logic                    stop_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_q;
    logic                    txd_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    xfer;

    // Ready only while idle; held low for every cycle reset is asserted.
    assign s.tready = (state_q == ST_IDLE) && !reset;
    assign xfer     = s.tvalid && s.tready;

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

    // Baud counter wraps at the end of every bit period.
    always_comb begin
        bit_end = (baud_q == BAUD_LAST);
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    // Frame sequencer: state, counters, shift register and registered outputs.
    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift register is cleared too, so an abandoned byte cannot leak into a later frame.
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    txd_q  <= 1'b1;
                    if (xfer) begin
                        state_q <= ST_START;
                        shift_q <= s.tdata;
                        par_q   <= (^s.tdata) ^ ODD_PARITY;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                    end
                end

                ST_DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (HAS_PARITY) begin
                                state_q <= ST_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                stop_q  <= 1'b0;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                            txd_q <= shift_q[1];
                        end
                    end
                end

                ST_PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        stop_q  <= 1'b0;
                        txd_q   <= 1'b1;
                    end
                end

                ST_STOP: begin
                    baud_q <= baud_d;
                    txd_q  <= 1'b1;
                    if (stop_q == STOP_LAST && baud_q == BAUD_PRE) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        if (stop_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                            stop_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Scoreboard bench for axis_uart_tx. Four instances cover the parity and
// stop-bit variants; drivers push accepted bytes into per-instance expected
// queues, and independent monitors decode txd and compare frame by frame
// against a bit-level model of the frame format.
module tb_axis_uart_tx;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CPB = 4;

    // Instance configurations: 0 = no parity/1 stop, 1 = even/1 stop,
    // 2 = odd/1 stop, 3 = no parity/2 stop.
    function automatic int par_of(input int g);
        case (g)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    // Frame length in bit periods.
    function automatic int frame_bits(input int g);
        return 1 + DW + ((par_of(g) != 0) ? 1 : 0) + stop_of(g);
    endfunction

    // Expected line level during bit period idx of a frame carrying b.
    function automatic logic model_bit(input int g, input logic [DW-1:0] b, input int idx);
        int ones;
        ones = $countones(b);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return b[idx-1];
        if (par_of(g) != 0 && idx == DW + 1) begin
            if (par_of(g) == 2) return 1'(ones % 2);
            return 1'(1 - (ones % 2));
        end
        return 1'b1;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            xfer_cyc;
    } xfer_t;

    logic          clk;
    logic          reset;
    logic          jitter;
    int            cyc;
    logic [N-1:0]  txd_w;
    logic [N-1:0]  busy_w;
    logic [N-1:0]  done_w;
    logic [N-1:0]  tready_w;

    logic [DW-1:0] stim_q   [N][$];
    xfer_t         exp_q    [N][$];
    int            start_log[N][$];
    logic [DW-1:0] byte_log [N][$];
    int            frames_done[N];
    int            done_at    [N];
    logic [DW-1:0] last_byte  [N];
    logic [15:0]   last_bits  [N];
    logic          last_par   [N];
    int            exp_frames [N];

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    for (genvar g = 0; g < N; g++) begin : gen_dut
        axis_uart_tx_if #(.DATA_WIDTH(DW)) s_if ();

        axis_uart_tx #(
            .DATA_WIDTH  (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY      (par_of(g)),
            .STOP_BITS   (stop_of(g))
        ) dut (
            .clk  (clk),
            .reset(reset),
            .s    (s_if),
            .txd  (txd_w[g]),
            .busy (busy_w[g]),
            .done (done_w[g])
        );

        assign tready_w[g] = s_if.tready;

        // Driver: presents queued bytes; an accepted byte becomes an expectation.
        initial begin : drv
            xfer_t t;
            s_if.tvalid = 1'b0;
            s_if.tdata  = '0;
            forever begin
                @(negedge clk);
                if (stim_q[g].size() == 0) begin
                    s_if.tvalid = 1'b0;
                    s_if.tdata  = DW'($urandom);
                end else begin
                    s_if.tvalid = 1'b1;
                    s_if.tdata  = stim_q[g][0];
                    #1;
                    if (s_if.tready === 1'b1) begin
                        t.data     = stim_q[g].pop_front();
                        t.xfer_cyc = cyc + 1;
                        exp_q[g].push_back(t);
                    end else if (jitter && $urandom_range(1) == 1) begin
                        s_if.tvalid = 1'b0;
                        s_if.tdata  = DW'($urandom);
                    end
                end
            end
        end

        // Monitor: decodes txd and checks each frame against the model.
        initial begin : mon
            int            k, bi, bad_bits, bad_done, bad_ctl, flen;
            logic          in_frame, post;
            logic [DW-1:0] dec;
            logic [15:0]   bits;
            xfer_t         cur;
            in_frame = 1'b0;
            post     = 1'b0;
            k        = 0;
            flen     = frame_bits(g) * CPB;
            forever begin
                @(negedge clk);
                #2;
                if (reset === 1'b1) begin
                    in_frame = 1'b0;
                    post     = 1'b0;
                    continue;
                end
                if (post) begin
                    post = 1'b0;
                    check($sformatf("d%0d idle_gap{txd,busy,done,ready}", g),
                          {28'd0, txd_w[g], busy_w[g], done_w[g], tready_w[g]}, 32'b1001);
                end
                if (!in_frame && txd_w[g] === 1'b0) begin
                    in_frame    = 1'b1;
                    k           = 0;
                    bad_bits    = 0;
                    bad_done    = 0;
                    bad_ctl     = 0;
                    dec         = '0;
                    bits        = '0;
                    done_at[g]  = 0;
                    check($sformatf("d%0d frame_expected", g), 32'(exp_q[g].size() > 0), 32'd1);
                    if (exp_q[g].size() > 0) begin
                        cur = exp_q[g].pop_front();
                    end else begin
                        cur.data     = '0;
                        cur.xfer_cyc = cyc;
                    end
                    check($sformatf("d%0d start_cycle", g), 32'(cyc), 32'(cur.xfer_cyc));
                    start_log[g].push_back(cyc);
                end
                if (in_frame) begin
                    bi = k / CPB;
                    if (txd_w[g] !== model_bit(g, cur.data, bi)) bad_bits++;
                    if (k % CPB == CPB / 2) begin
                        bits[bi] = txd_w[g];
                        if (bi >= 1 && bi <= DW) dec[bi-1] = txd_w[g];
                    end
                    if (done_w[g] === 1'b1 && done_at[g] == 0) done_at[g] = k + 1;
                    if (done_w[g] !== 1'(k == flen - 1)) bad_done++;
                    if (busy_w[g] !== 1'b1 || tready_w[g] !== 1'b0) bad_ctl++;
                    k++;
                    if (k == flen) begin
                        check($sformatf("d%0d byte", g), 32'(dec), 32'(cur.data));
                        check($sformatf("d%0d bad_bit_cycles", g), 32'(bad_bits), 32'd0);
                        check($sformatf("d%0d bad_done_cycles", g), 32'(bad_done), 32'd0);
                        check($sformatf("d%0d bad_busy_ready_cycles", g), 32'(bad_ctl), 32'd0);
                        last_byte[g] = dec;
                        last_bits[g] = bits;
                        last_par[g]  = bits[DW+1];
                        byte_log[g].push_back(dec);
                        frames_done[g]++;
                        in_frame = 1'b0;
                        post     = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [DW-1:0] b);
        stim_q[g].push_back(b);
        exp_frames[g]++;
    endtask

    task automatic wait_frames(input int g, input int budget);
        int t;
        t = 0;
        while (frames_done[g] < exp_frames[g] && t < budget) begin
            @(negedge clk);
            #3;
            t++;
        end
        check($sformatf("d%0d frames_completed", g), 32'(frames_done[g]), 32'(exp_frames[g]));
    endtask

    initial begin : main
        int bad, s0, t, sz;
        n_checks = 0;
        n_fail   = 0;
        jitter   = 1'b0;
        for (int g = 0; g < N; g++) begin
            frames_done[g] = 0;
            done_at[g]     = 0;
            exp_frames[g]  = 0;
        end
        reset = 1'b1;

        // Reset state, sampled while reset is still high.
        repeat (3) @(negedge clk);
        check("reset txd", 32'(txd_w), 32'hF);
        check("reset busy", 32'(busy_w), 32'h0);
        check("reset done", 32'(done_w), 32'h0);
        check("reset tready", 32'(tready_w), 32'h0);
        reset = 1'b0;
        #1;
        check("tready after reset release", 32'(tready_w), 32'hF);

        // Empty stream: line idles high, not busy, always ready.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (txd_w !== 4'hF || busy_w !== 4'h0 || tready_w !== 4'hF || done_w !== 4'h0) bad++;
        end
        check("stall idle cycles bad", 32'(bad), 32'd0);

        // Single byte, no parity, one stop bit.
        send(0, 8'hA5);
        wait_frames(0, 200);
        check("T1 done cycle", 32'(done_at[0]), 32'd40);
        check("T1 line bits", 32'(last_bits[0][9:0]), 32'h34A);
        check("T1 byte", 32'(last_byte[0]), 32'hA5);

        // Parity variants.
        send(1, 8'hA5);
        send(2, 8'hA5);
        wait_frames(1, 200);
        wait_frames(2, 200);
        check("T2 even parity A5", 32'(last_par[1]), 32'd0);
        check("T2 odd parity A5", 32'(last_par[2]), 32'd1);
        check("T2 even frame len", 32'(done_at[1]), 32'd44);
        check("T2 odd frame len", 32'(done_at[2]), 32'd44);
        send(1, 8'h01);
        wait_frames(1, 200);
        check("T2 even parity 01", 32'(last_par[1]), 32'd1);

        // Back-to-back frames with tvalid held high.
        send(0, 8'h00);
        send(0, 8'hFF);
        send(0, 8'h3C);
        wait_frames(0, 400);
        sz = start_log[0].size();
        check("T3 gap 1", 32'(start_log[0][sz-2] - start_log[0][sz-3]), 32'(frame_bits(0) * CPB + 1));
        check("T3 gap 2", 32'(start_log[0][sz-1] - start_log[0][sz-2]), 32'(frame_bits(0) * CPB + 1));
        sz = byte_log[0].size();
        check("T3 byte 0", 32'(byte_log[0][sz-3]), 32'h00);
        check("T3 byte 1", 32'(byte_log[0][sz-2]), 32'hFF);
        check("T3 byte 2", 32'(byte_log[0][sz-1]), 32'h3C);

        // Two stop bits.
        send(3, 8'h55);
        wait_frames(3, 200);
        check("T4 frame len", 32'(done_at[3]), 32'd44);
        check("T4 byte", 32'(last_byte[3]), 32'h55);

        // Reset during data bit 3; a byte is offered to instance 1 during reset.
        s0 = start_log[0].size();
        stim_q[0].push_back(8'hA5);
        t = 0;
        while (start_log[0].size() == s0 && t < 200) begin
            @(negedge clk);
            #3;
            t++;
        end
        check("T5 frame started", 32'(start_log[0].size()), 32'(s0 + 1));
        repeat (16) @(negedge clk);
        #1;
        send(1, 8'h77);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("T5 txd after reset", 32'(txd_w[1:0]), 32'h3);
        check("T5 busy after reset", 32'(busy_w[0]), 32'd0);
        check("T5 tready during reset", 32'(tready_w[1:0]), 32'h0);
        reset = 1'b0;
        #1;
        check("T5 tready after reset", 32'(tready_w[0]), 32'd1);
        send(0, 8'h5A);
        wait_frames(0, 200);
        wait_frames(1, 200);
        check("T5 byte after reset", 32'(last_byte[0]), 32'h5A);
        check("T5 byte held off by reset", 32'(last_byte[1]), 32'h77);

        // Random traffic into every instance, with tvalid jitter while stalled.
        jitter = 1'b1;
        for (int i = 0; i < 32; i++) begin
            for (int g = 0; g < N; g++) send(g, DW'($urandom));
            if ($urandom_range(3) == 0) repeat ($urandom_range(60)) @(negedge clk);
        end
        for (int g = 0; g < N; g++) wait_frames(g, 8000);

        repeat (5) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check($sformatf("d%0d leftover expectations", g), 32'(exp_q[g].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
